// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - shared pattern modes, FSM states and LFSR taps for ram_bist
package ram_bist_pkg;

  localparam logic [1:0] MODE_INC  = 2'd0;
  localparam logic [1:0] MODE_WALK = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;
  localparam logic [1:0] MODE_INV  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Right-shifting Galois masks: bit (e-1) set for each polynomial exponent e.
  function automatic logic [63:0] lfsr_taps(input int w);
    case (w)
      4:       return 64'h0000_0000_0000_000C;
      5:       return 64'h0000_0000_0000_0014;
      6:       return 64'h0000_0000_0000_0030;
      7:       return 64'h0000_0000_0000_0060;
      8:       return 64'h0000_0000_0000_00B8;
      9:       return 64'h0000_0000_0000_0110;
      10:      return 64'h0000_0000_0000_0240;
      11:      return 64'h0000_0000_0000_0500;
      12:      return 64'h0000_0000_0000_0829;
      16:      return 64'h0000_0000_0000_B400;
      32:      return 64'h0000_0000_8020_0003;
      64:      return 64'hD800_0000_0000_0000;
      default: return (64'd1 << (w - 1)) | 64'd1;
    endcase
  endfunction

endpackage

// File: rtl/ram_bist_patgen.sv
// rtl/ram_bist_patgen.sv - restartable BIST data pattern generator
// o_word is word k after k steps following a load.
module ram_bist_patgen
  import ram_bist_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_seed,
  output logic [DATA_W-1:0] o_word
);

  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

  logic [1:0]        r_mode;
  logic [DATA_W-1:0] r_seed;
  logic [DATA_W-1:0] r_word;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] w_nz_seed;
  logic [DATA_W-1:0] w_init;
  logic [DATA_W-1:0] w_next;
  logic [ADDR_W-1:0] w_idx_next;

  function automatic logic [DATA_W-1:0] inv_word(input logic [ADDR_W-1:0] idx,
                                                  input logic [DATA_W-1:0] s);
    logic [ADDR_W-1:0] n;
    n = ~idx;
    return DATA_W'(n) ^ s;
  endfunction

  assign w_nz_seed  = (i_seed == '0) ? DATA_W'(1) : i_seed;
  assign w_idx_next = r_idx + ADDR_W'(1);

  always_comb begin
    w_init = i_seed;
    case (i_mode)
      MODE_INC:  w_init = i_seed;
      MODE_WALK: w_init = w_nz_seed;
      MODE_LFSR: w_init = w_nz_seed;
      MODE_INV:  w_init = inv_word('0, i_seed);
      default:   w_init = i_seed;
    endcase
  end

  always_comb begin
    w_next = r_word;
    case (r_mode)
      MODE_INC:  w_next = r_word + DATA_W'(1);
      MODE_WALK: w_next = {r_word[DATA_W-2:0], r_word[DATA_W-1]};
      MODE_LFSR: w_next = r_word[0] ? ((r_word >> 1) ^ TAPS) : (r_word >> 1);
      MODE_INV:  w_next = inv_word(w_idx_next, r_seed);
      default:   w_next = r_word;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode <= '0;
      r_seed <= '0;
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_mode <= i_mode;
      r_seed <= i_seed;
      r_word <= w_init;
      r_idx  <= '0;
    end else if (i_step) begin
      r_word <= w_next;
      r_idx  <= w_idx_next;
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/ram_bist.sv
// rtl/ram_bist.sv - fill/read-back self-test engine for a simple dual-port RAM
// Write and expected streams come from two identical generators restarted from the same seed.
module ram_bist
  import ram_bist_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 9,
  parameter int RD_LATENCY = 1,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [1:0]           i_mode,
  input  logic [DATA_W-1:0]    i_seed,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_pass,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic [ADDR_W-1:0]    o_first_err_addr,
  output logic [DATA_W-1:0]    o_first_err_exp,
  output logic [DATA_W-1:0]    o_first_err_got,
  output logic                 o_ram_we,
  output logic [ADDR_W-1:0]    o_ram_waddr,
  output logic [DATA_W-1:0]    o_ram_wdata,
  output logic [ADDR_W-1:0]    o_ram_raddr,
  input  logic [DATA_W-1:0]    i_ram_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [2:0]        DRAIN_END = 3'(RD_LATENCY);

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_W-1:0]     r_waddr;
  logic [ADDR_W-1:0]     r_raddr;
  logic [2:0]            r_drain;
  logic [1:0]            r_mode;
  logic [DATA_W-1:0]     r_seed;
  logic [ERR_CNT_W-1:0]  r_err_cnt;
  logic [ADDR_W-1:0]     r_first_addr;
  logic [DATA_W-1:0]     r_first_exp;
  logic [DATA_W-1:0]     r_first_got;
  logic                  r_pass;
  logic                  r_pv [RD_LATENCY];
  logic [ADDR_W-1:0]     r_pa [RD_LATENCY];
  logic [DATA_W-1:0]     r_pe [RD_LATENCY];
  logic                  w_start_acc;
  logic                  w_rgen_load;
  logic                  w_mismatch;
  logic [DATA_W-1:0]     w_wdata;
  logic [DATA_W-1:0]     w_exp;

  assign w_start_acc = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_rgen_load = (r_state == ST_WRITE) && (r_waddr == LAST_ADDR);
  assign w_mismatch  = r_pv[RD_LATENCY-1] && (i_ram_rdata != r_pe[RD_LATENCY-1]);

  ram_bist_patgen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_wgen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_start_acc),
    .i_step (r_state == ST_WRITE),
    .i_mode (i_mode),
    .i_seed (i_seed),
    .o_word (w_wdata)
  );

  ram_bist_patgen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rgen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_rgen_load),
    .i_step (r_state == ST_READ),
    .i_mode (r_mode),
    .i_seed (r_seed),
    .o_word (w_exp)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // DRAIN lasts RD_LATENCY+1 cycles: the last compare lands, then pass samples a settled count.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next_state = ST_WRITE;
      ST_WRITE: if (r_waddr == LAST_ADDR) w_next_state = ST_READ;
      ST_READ:  if (r_raddr == LAST_ADDR) w_next_state = ST_DRAIN;
      ST_DRAIN: if (r_drain == DRAIN_END) w_next_state = ST_DONE;
      ST_DONE:  if (i_start) w_next_state = ST_WRITE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_waddr <= '0;
      r_raddr <= '0;
      r_drain <= '0;
      r_mode  <= '0;
      r_seed  <= '0;
    end else if (w_start_acc) begin
      r_waddr <= '0;
      r_raddr <= '0;
      r_drain <= '0;
      r_mode  <= i_mode;
      r_seed  <= i_seed;
    end else begin
      if (r_state == ST_WRITE && r_waddr != LAST_ADDR) r_waddr <= r_waddr + ADDR_W'(1);
      if (r_state == ST_READ && r_raddr != LAST_ADDR)  r_raddr <= r_raddr + ADDR_W'(1);
      if (r_state == ST_DRAIN)                         r_drain <= r_drain + 3'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_pv[i] <= 1'b0;
        r_pa[i] <= '0;
        r_pe[i] <= '0;
      end
    end else begin
      r_pv[0] <= (r_state == ST_READ);
      r_pa[0] <= r_raddr;
      r_pe[0] <= w_exp;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pa[i] <= r_pa[i-1];
        r_pe[i] <= r_pe[i-1];
      end
    end
  end

  // A saturated count never returns to zero, so err_cnt==0 marks the first mismatch.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start_acc) begin
      r_err_cnt    <= '0;
      r_first_addr <= '0;
      r_first_exp  <= '0;
      r_first_got  <= '0;
      r_pass       <= 1'b0;
    end else begin
      if (w_mismatch) begin
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        if (r_err_cnt == '0) begin
          r_first_addr <= r_pa[RD_LATENCY-1];
          r_first_exp  <= r_pe[RD_LATENCY-1];
          r_first_got  <= i_ram_rdata;
        end
      end
      if (r_state == ST_DRAIN && w_next_state == ST_DONE) r_pass <= (r_err_cnt == '0);
    end
  end

  assign o_busy           = (r_state == ST_WRITE) || (r_state == ST_READ) || (r_state == ST_DRAIN);
  assign o_done           = (r_state == ST_DONE);
  assign o_pass           = r_pass;
  assign o_err_cnt        = r_err_cnt;
  assign o_first_err_addr = r_first_addr;
  assign o_first_err_exp  = r_first_exp;
  assign o_first_err_got  = r_first_got;
  assign o_ram_we         = (r_state == ST_WRITE);
  assign o_ram_waddr      = r_waddr;
  assign o_ram_wdata      = w_wdata;
  assign o_ram_raddr      = r_raddr;

endmodule

// File: tb/tb_ram_bist.sv
// tb/tb_ram_bist.sv - directed self-checking bench for ram_bist with latency-1 and latency-3 RAM models
module tb_ram_bist;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a;
  logic        start_b;
  logic [1:0]  mode;
  logic [15:0] seed;
  int          fault;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  logic        a_busy, a_done, a_pass, a_we;
  logic [15:0] a_err, a_fee, a_feg, a_wd, a_rd;
  logic [3:0]  a_fea, a_wa, a_ra;
  logic        b_busy, b_done, b_pass, b_we;
  logic [2:0]  b_err;
  logic [15:0] b_fee, b_feg, b_wd, b_rd;
  logic [3:0]  b_fea, b_wa, b_ra;

  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];
  logic [15:0] pipe_b [3];
  logic [15:0] snap [16];

  ram_bist #(.DATA_W(16), .ADDR_W(4), .RD_LATENCY(1), .ERR_CNT_W(16)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_mode(mode), .i_seed(seed),
    .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass), .o_err_cnt(a_err),
    .o_first_err_addr(a_fea), .o_first_err_exp(a_fee), .o_first_err_got(a_feg),
    .o_ram_we(a_we), .o_ram_waddr(a_wa), .o_ram_wdata(a_wd), .o_ram_raddr(a_ra),
    .i_ram_rdata(a_rd)
  );

  ram_bist #(.DATA_W(16), .ADDR_W(4), .RD_LATENCY(3), .ERR_CNT_W(3)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_mode(mode), .i_seed(seed),
    .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass), .o_err_cnt(b_err),
    .o_first_err_addr(b_fea), .o_first_err_exp(b_fee), .o_first_err_got(b_feg),
    .o_ram_we(b_we), .o_ram_waddr(b_wa), .o_ram_wdata(b_wd), .o_ram_raddr(b_ra),
    .i_ram_rdata(b_rd)
  );

  // fault 1: bit0 forced on reads of address 5; fault 2: every read returns all ones.
  function automatic logic [15:0] corrupt(input logic [3:0] a, input logic [15:0] d);
    if (fault == 1) return (a == 4'd5) ? (d | 16'h0001) : d;
    if (fault == 2) return 16'hFFFF;
    return d;
  endfunction

  always @(posedge clk) begin
    if (a_we) mem_a[a_wa] <= a_wd;
    a_rd <= corrupt(a_ra, mem_a[a_ra]);
  end

  always @(posedge clk) begin
    if (b_we) mem_b[b_wa] <= b_wd;
    pipe_b[0] <= corrupt(b_ra, mem_b[b_ra]);
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign b_rd = pipe_b[2];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  typedef struct {
    int          sel;
    int          flt;
    logic [1:0]  mode;
    logic [15:0] seed;
    int          poke;
    int          lat;
    logic        pass;
    logic [15:0] err;
    logic [3:0]  fea;
    logic [15:0] fee;
    logic [15:0] feg;
    logic [3:0]  maddr;
    logic [15:0] mdata;
  } vec_t;

  vec_t vecs [6];

  // Latency is counted in rising edges after the edge that samples start.
  task automatic run_vec(input vec_t v);
    int   lat;
    logic dn;
    fault = v.flt;
    @(negedge clk);
    mode = v.mode;
    seed = v.seed;
    start_a = (v.sel == 0);
    start_b = (v.sel == 1);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    lat = 0;
    dn = (v.sel == 0) ? a_done : b_done;
    while (!dn && lat < 300) begin
      start_a = (v.sel == 0) && (v.poke > 0) && (lat == v.poke);
      start_b = (v.sel == 1) && (v.poke > 0) && (lat == v.poke);
      @(negedge clk);
      lat++;
      dn = (v.sel == 0) ? a_done : b_done;
    end
    start_a = 1'b0;
    start_b = 1'b0;
    chk("done_latency", lat, v.lat);
    if (v.sel == 0) begin
      chk("busy_at_done", a_busy, 0);
      chk("pass", a_pass, v.pass);
      chk("err_cnt", a_err, v.err);
      chk("first_err_addr", a_fea, v.fea);
      chk("first_err_exp", a_fee, v.fee);
      chk("first_err_got", a_feg, v.feg);
      chk("ram_word", mem_a[v.maddr], v.mdata);
    end else begin
      chk("busy_at_done", b_busy, 0);
      chk("pass", b_pass, v.pass);
      chk("err_cnt", b_err, v.err);
      chk("first_err_addr", b_fea, v.fea);
      chk("first_err_exp", b_fee, v.fee);
      chk("first_err_got", b_feg, v.feg);
      chk("ram_word", mem_b[v.maddr], v.mdata);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    int   n;
    logic [15:0] w;

    //          sel flt mode   seed      poke lat pass  err    fea   fee       feg       maddr mdata
    vecs[0] = '{0, 0, 2'd0, 16'h0001, 0,  34, 1'b1, 16'd0, 4'd0, 16'h0000, 16'h0000, 4'd15, 16'h0010};
    vecs[1] = '{0, 1, 2'd0, 16'h0001, 0,  34, 1'b0, 16'd1, 4'd5, 16'h0006, 16'h0007, 4'd5,  16'h0006};
    vecs[2] = '{0, 0, 2'd1, 16'h0000, 0,  34, 1'b1, 16'd0, 4'd0, 16'h0000, 16'h0000, 4'd3,  16'h0008};
    vecs[3] = '{1, 0, 2'd1, 16'h0000, 0,  36, 1'b1, 16'd0, 4'd0, 16'h0000, 16'h0000, 4'd15, 16'h8000};
    vecs[4] = '{1, 2, 2'd0, 16'h0000, 0,  36, 1'b0, 16'd7, 4'd0, 16'h0000, 16'hFFFF, 4'd2,  16'h0002};
    vecs[5] = '{0, 0, 2'd3, 16'h1234, 10, 34, 1'b1, 16'd0, 4'd0, 16'h0000, 16'h0000, 4'd0,  16'h123B};

    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    mode = 2'd0;
    seed = 16'h0;
    fault = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy_a", a_busy, 0);
    chk("rst_done_a", a_done, 0);
    chk("rst_pass_a", a_pass, 0);
    chk("rst_err_a", a_err, 0);
    chk("rst_we_a", a_we, 0);
    chk("rst_raddr_a", a_ra, 0);
    chk("rst_wdata_a", a_wd, 0);
    chk("rst_busy_b", b_busy, 0);
    chk("rst_we_b", b_we, 0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Abort mid-fill, then a fresh start must still run a clean test.
    fault = 0;
    @(negedge clk);
    mode = 2'd0;
    seed = 16'h0001;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (!(a_we && a_wa == 4'd7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_waddr7", a_wa, 7);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_we", a_we, 0);
    chk("abort_busy", a_busy, 0);
    chk("abort_done", a_done, 0);
    chk("abort_err", a_err, 0);
    rst = 1'b0;
    run_vec(vecs[0]);

    // Reset in DONE clears failure results.
    run_vec(vecs[1]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_clear_done", a_done, 0);
    chk("rst_clear_err", a_err, 0);
    chk("rst_clear_fea", a_fea, 0);
    chk("rst_clear_feg", a_feg, 0);

    // LFSR: a zero seed behaves exactly like seed 1.
    v = '{0, 0, 2'd2, 16'h0000, 0, 34, 1'b1, 16'd0, 4'd0, 16'h0, 16'h0, 4'd1, 16'hB400};
    run_vec(v);
    for (int k = 0; k < 16; k++) snap[k] = mem_a[k];
    v.seed = 16'h0001;
    run_vec(v);
    w = 16'h0001;
    for (int k = 0; k < 16; k++) begin
      chk("lfsr_seed0_vs_seed1", snap[k], mem_a[k]);
      chk("lfsr_vs_model", mem_a[k], w);
      w = w[0] ? ((w >> 1) ^ 16'hB400) : (w >> 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
